// File: rtl/axi4_rw_arbiter.sv
// ============================================================================
//  Module      : axi4_rw_arbiter
//  Description : Burst-level AW/AR arbiter for a single-ported AXI4 slave.
//                It keeps at most one burst outstanding and alternates
//                fairly between the write and read paths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_rw_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 s_AWVALID,
    output logic                 s_AWREADY,
    output logic                 m_AWVALID,
    input  logic                 m_AWREADY,
    input  logic                 s_ARVALID,
    output logic                 s_ARREADY,
    output logic                 m_ARVALID,
    input  logic                 m_ARREADY,
    input  logic                 BVALID,
    input  logic                 BREADY,
    input  logic                 RVALID,
    input  logic                 RREADY,
    input  logic                 RLAST,
    output logic                 wr_active,
    output logic                 rd_active,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] wr_grant_cnt,
    output logic [CNT_WIDTH-1:0] rd_grant_cnt
);

    localparam int                 c_WD_W    = $clog2(TIMEOUT);
    localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    generate
        if (TIMEOUT < 2 || ADDR_WIDTH < 1) begin : g_param_check
            $error("axi4_rw_arbiter: TIMEOUT must be >= 2 and ADDR_WIDTH >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_WAIT = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_last_wr;     // 1: last grant was WRITE, 0: READ
    logic [c_WD_W-1:0]      r_wdog;
    logic [CNT_WIDTH-1:0]   r_wr_cnt;
    logic [CNT_WIDTH-1:0]   r_rd_cnt;
    logic                   r_wr_active;
    logic                   r_rd_active;

    logic w_aw_hs;
    logic w_ar_hs;
    logic w_b_done;
    logic w_r_done;
    logic w_wd_expired;
    logic w_timeout;

    assign w_aw_hs      = (r_state == ST_WR_ADDR) && s_AWVALID && m_AWREADY;
    assign w_ar_hs      = (r_state == ST_RD_ADDR) && s_ARVALID && m_ARREADY;
    assign w_b_done     = (r_state == ST_WR_WAIT) && BVALID && BREADY;
    assign w_r_done     = (r_state == ST_RD_WAIT) && RVALID && RREADY && RLAST;
    assign w_wd_expired = (r_wdog == c_WD_LAST);
    // Completion in the expiry cycle wins over the watchdog.
    assign w_timeout    = ((r_state == ST_WR_WAIT) && w_wd_expired && !w_b_done) ||
                          ((r_state == ST_RD_WAIT) && w_wd_expired && !w_r_done);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= ST_IDLE;
            r_last_wr   <= 1'b0;
            r_wdog      <= '0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_wr_active <= 1'b0;
            r_rd_active <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_AWVALID && (!s_ARVALID || !r_last_wr)) begin
                        r_state     <= ST_WR_ADDR;
                        r_wr_active <= 1'b1;
                    end else if (s_ARVALID) begin
                        r_state     <= ST_RD_ADDR;
                        r_rd_active <= 1'b1;
                    end
                end
                ST_WR_ADDR: begin
                    if (w_aw_hs) begin
                        r_state   <= ST_WR_WAIT;
                        r_last_wr <= 1'b1;
                        r_wdog    <= '0;
                        if (r_wr_cnt != c_CNT_MAX) begin
                            r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_WR_WAIT: begin
                    if (w_b_done || w_timeout) begin
                        r_state     <= ST_IDLE;
                        r_wr_active <= 1'b0;
                    end else begin
                        r_wdog <= r_wdog + c_WD_W'(1);
                    end
                end
                ST_RD_ADDR: begin
                    if (w_ar_hs) begin
                        r_state   <= ST_RD_WAIT;
                        r_last_wr <= 1'b0;
                        r_wdog    <= '0;
                        if (r_rd_cnt != c_CNT_MAX) begin
                            r_rd_cnt <= r_rd_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (w_r_done || w_timeout) begin
                        r_state     <= ST_IDLE;
                        r_rd_active <= 1'b0;
                    end else begin
                        r_wdog <= r_wdog + c_WD_W'(1);
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_wr_active <= 1'b0;
                    r_rd_active <= 1'b0;
                end
            endcase
        end
    end

    // Handshake gating is combinational from state so the grant costs no extra cycle.
    assign m_AWVALID    = (r_state == ST_WR_ADDR) && s_AWVALID;
    assign s_AWREADY    = (r_state == ST_WR_ADDR) && m_AWREADY;
    assign m_ARVALID    = (r_state == ST_RD_ADDR) && s_ARVALID;
    assign s_ARREADY    = (r_state == ST_RD_ADDR) && m_ARREADY;

    assign wr_active    = r_wr_active;
    assign rd_active    = r_rd_active;
    assign timeout_err  = w_timeout;
    assign wr_grant_cnt = r_wr_cnt;
    assign rd_grant_cnt = r_rd_cnt;

endmodule

`default_nettype wire

// File: tb/tb_axi4_rw_arbiter.sv
// ============================================================================
//  Module      : tb_axi4_rw_arbiter
//  Description : Scoreboard bench for axi4_rw_arbiter (TIMEOUT=8, CNT_WIDTH=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4_rw_arbiter;

    localparam int c_CW = 2;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic            s_AWVALID, s_AWREADY, m_AWVALID, m_AWREADY;
    logic            s_ARVALID, s_ARREADY, m_ARVALID, m_ARREADY;
    logic            BVALID, BREADY, RVALID, RREADY, RLAST;
    logic            wr_active, rd_active, timeout_err;
    logic [c_CW-1:0] wr_grant_cnt, rd_grant_cnt;

    int  n_chk = 0;
    int  n_err = 0;
    byte q_exp[$];

    axi4_rw_arbiter #(.ADDR_WIDTH(10), .TIMEOUT(8), .CNT_WIDTH(c_CW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
        .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY),
        .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
        .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
        .BVALID(BVALID), .BREADY(BREADY),
        .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
        .wr_active(wr_active), .rd_active(rd_active), .timeout_err(timeout_err),
        .wr_grant_cnt(wr_grant_cnt), .rd_grant_cnt(rd_grant_cnt)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_pop(input byte got);
        byte exp;
        n_chk++;
        if (q_exp.size() == 0) begin
            n_err++;
            $display("FAIL event_order: got %c, expected no event at %0t", got, $time);
        end else begin
            exp = q_exp.pop_front();
            if (exp != got) begin
                n_err++;
                $display("FAIL event_order: got %c, expected %c at %0t", got, exp, $time);
            end
        end
    endtask

    // Monitor: grant/timeout events against the scoreboard, plus mutual exclusion.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (m_AWVALID && m_AWREADY) sb_pop("W");
            if (m_ARVALID && m_ARREADY) sb_pop("R");
            if (timeout_err)            sb_pop("T");
            if (wr_active) chk("ar_blocked_in_write", int'(s_ARREADY | m_ARVALID), 0);
            if (rd_active) chk("aw_blocked_in_read",  int'(s_AWREADY | m_AWVALID), 0);
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        chk("scoreboard_drained", q_exp.size(), 0);
        q_exp.delete();
        ARESET = 1'b1;
        s_AWVALID = 0; s_ARVALID = 0; m_AWREADY = 1; m_ARREADY = 1;
        BVALID = 0; BREADY = 0; RVALID = 0; RREADY = 0; RLAST = 0;
        tick();
        tick();
        ARESET = 1'b0;
    endtask

    // Waits (bounded) for the current cycle to carry a forwarded AW or AR handshake.
    task automatic wait_hs(output bit is_wr);
        bit found = 0;
        is_wr = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (m_AWVALID && m_AWREADY) begin found = 1; is_wr = 1; break; end
            if (m_ARVALID && m_ARREADY) begin found = 1; is_wr = 0; break; end
            tick();
        end
        if (!found) chk("handshake_within_bound", 0, 1);
    endtask

    // One complete burst; completion lands on the n-th WAIT cycle.
    task automatic burst(input bit wr, input int n);
        bit got_wr;
        q_exp.push_back(wr ? "W" : "R");
        if (wr) s_AWVALID = 1; else s_ARVALID = 1;
        wait_hs(got_wr);
        tick();
        if (wr) s_AWVALID = 0; else s_ARVALID = 0;
        for (int c = 1; c < n; c++) tick();
        if (wr) begin BVALID = 1; BREADY = 1; end
        else begin RVALID = 1; RREADY = 1; RLAST = 1; end
        tick();
        BVALID = 0; BREADY = 0; RVALID = 0; RREADY = 0; RLAST = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit is_wr;

        // ---- reset state ----
        do_reset();
        #1;
        chk("rst_wr_active", wr_active, 0);
        chk("rst_rd_active", rd_active, 0);
        chk("rst_timeout",   timeout_err, 0);
        chk("rst_m_awvalid", m_AWVALID, 0);
        chk("rst_s_arready", s_ARREADY, 0);
        chk("rst_wr_cnt",    wr_grant_cnt, 0);
        chk("rst_rd_cnt",    rd_grant_cnt, 0);

        // ---- single write, exact cycle timing ----
        tick();                                         // cycle 1
        s_AWVALID = 1;
        q_exp.push_back("W");
        #1;
        chk("sw_c1_m_awvalid", m_AWVALID, 0);
        chk("sw_c1_wr_active", wr_active, 0);
        tick();                                         // cycle 2
        chk("sw_c2_m_awvalid", m_AWVALID, 1);
        chk("sw_c2_wr_active", wr_active, 1);
        tick();                                         // cycle 3
        s_AWVALID = 0;
        for (int c = 3; c <= 6; c++) begin
            if (c > 3) tick();
            if (c == 6) begin BVALID = 1; BREADY = 1; end
            #1;
            chk("sw_wait_wr_active", wr_active, 1);
            chk("sw_wait_m_awvalid", m_AWVALID, 0);
        end
        tick();                                         // cycle 7
        BVALID = 0; BREADY = 0;
        chk("sw_c7_wr_active", wr_active, 0);
        chk("sw_wr_cnt", wr_grant_cnt, 1);
        chk("sw_rd_cnt", rd_grant_cnt, 0);

        // ---- contention: both VALIDs held, 4 bursts ----
        do_reset();
        s_AWVALID = 1; s_ARVALID = 1;
        q_exp.push_back("W"); q_exp.push_back("R");
        q_exp.push_back("W"); q_exp.push_back("R");
        for (int b = 0; b < 4; b++) begin
            wait_hs(is_wr);
            chk("cont_order", int'(is_wr), (b % 2 == 0) ? 1 : 0);
            tick(); tick(); tick();
            if (is_wr) begin BVALID = 1; BREADY = 1; end
            else begin RVALID = 1; RREADY = 1; RLAST = 1; end
            tick();
            BVALID = 0; BREADY = 0; RVALID = 0; RREADY = 0; RLAST = 0;
        end
        s_AWVALID = 0; s_ARVALID = 0;
        #1;
        chk("cont_wr_cnt", wr_grant_cnt, 2);
        chk("cont_rd_cnt", rd_grant_cnt, 2);

        // ---- read burst, RLAST on beat 4 ----
        do_reset();
        s_ARVALID = 1;
        q_exp.push_back("R");
        wait_hs(is_wr);
        tick();
        s_ARVALID = 0;
        for (int b = 1; b <= 4; b++) begin
            RVALID = 1; RREADY = 1; RLAST = (b == 4);
            #1;
            chk("rb_rd_active_beat", rd_active, 1);
            tick();
        end
        RVALID = 0; RREADY = 0; RLAST = 0;
        chk("rb_rd_active_after", rd_active, 0);
        chk("rb_rd_cnt", rd_grant_cnt, 1);

        // ---- watchdog timeout with a pending read ----
        do_reset();
        s_AWVALID = 1; s_ARVALID = 1;
        q_exp.push_back("W"); q_exp.push_back("T"); q_exp.push_back("R");
        wait_hs(is_wr);
        chk("to_first_is_write", int'(is_wr), 1);
        tick();
        s_AWVALID = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) tick();
            #1;
            chk("to_timeout_err", timeout_err, (c == 8) ? 1 : 0);
        end
        tick();
        chk("to_idle_wr_active", wr_active, 0);
        chk("to_idle_rd_active", rd_active, 0);
        tick();
        chk("to_read_granted", int'(m_ARVALID && m_ARREADY), 1);
        tick();
        s_ARVALID = 0;
        RVALID = 1; RREADY = 1; RLAST = 1;
        tick();
        RVALID = 0; RREADY = 0; RLAST = 0;

        // ---- completion on the expiry cycle beats the watchdog ----
        do_reset();
        s_AWVALID = 1;
        q_exp.push_back("W");
        wait_hs(is_wr);
        tick();
        s_AWVALID = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) tick();
            if (c == 8) begin BVALID = 1; BREADY = 1; end
            #1;
            chk("tp_no_timeout", timeout_err, 0);
        end
        tick();
        BVALID = 0; BREADY = 0;
        chk("tp_wr_active_after", wr_active, 0);

        // ---- reset in RD_WAIT ----
        do_reset();
        burst(1'b1, 1);
        s_ARVALID = 1;
        q_exp.push_back("R");
        wait_hs(is_wr);
        tick();
        s_ARVALID = 0;
        tick();
        chk("mr_rd_active_before", rd_active, 1);
        ARESET = 1;
        tick();
        chk("mr_rd_active", rd_active, 0);
        chk("mr_wr_active", wr_active, 0);
        chk("mr_timeout",   timeout_err, 0);
        chk("mr_m_arvalid", m_ARVALID, 0);
        chk("mr_s_arready", s_ARREADY, 0);
        chk("mr_wr_cnt",    wr_grant_cnt, 0);
        chk("mr_rd_cnt",    rd_grant_cnt, 0);
        ARESET = 0;

        // ---- counter saturation ----
        do_reset();
        for (int i = 0; i < 5; i++) burst(1'b1, 1);
        #1;
        chk("sat_wr_cnt", wr_grant_cnt, 3);
        chk("sat_rd_cnt", rd_grant_cnt, 0);

        tick();
        chk("scoreboard_drained", q_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi4_rw_arbiter.md
# axi4_rw_arbiter

Burst-level arbiter between the write and read paths of one AXI4 master–slave link whose slave memory is single-ported. It sits on the AW and AR address channels, gates the handshakes so that at most one burst (write or read) is outstanding at a time, and alternates fairly when both are pending. A grant is held until the burst completes (B handshake or last R beat), or until a watchdog timeout expires. Saturating grant counters and a timeout pulse feed the verification environment's coverage and logging.

## Interface
- ADDR_WIDTH, 10: AW/AR address width (pass-through only).
- TIMEOUT, 1024: maximum cycles in a wait-for-completion state; must be ≥ 2.
- CNT_WIDTH, 16: width of the saturating grant counters.

- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- s_AWVALID / s_AWREADY  in / out  1 / 1  master-side write address handshake.
- m_AWVALID / m_AWREADY  out / in  1 / 1  slave-side write address handshake.
- s_ARVALID / s_ARREADY  in / out  1 / 1  master-side read address handshake.
- m_ARVALID / m_ARREADY  out / in  1 / 1  slave-side read address handshake.
- BVALID, BREADY  in  1 each  write response handshake, observed only.
- RVALID, RREADY, RLAST  in  1 each  read data handshake, observed only.
- wr_active, rd_active  out  1 each  high while a write or read grant is held.
- timeout_err  out  1  one-cycle pulse when the watchdog expires.
- wr_grant_cnt, rd_grant_cnt  out  CNT_WIDTH each  accepted AW/AR handshakes, saturating.

## Operation
- States: IDLE, WR_ADDR, WR_WAIT, RD_ADDR, RD_WAIT.
- IDLE: arbitration is performed only in this state.
  - s_AWVALID only → WR_ADDR.
  - s_ARVALID only → RD_ADDR.
  - Both → the path not equal to last_grant. last_grant resets to READ, so write wins the first tie.
  - Neither → stay in IDLE.
- WR_ADDR: m_AWVALID = s_AWVALID and s_AWREADY = m_AWREADY (combinational pass-through). On s_AWVALID&m_AWREADY → WR_WAIT, last_grant ← WRITE, wr_grant_cnt++.
- WR_WAIT: leave on BVALID&BREADY → IDLE.
- RD_ADDR / RD_WAIT: mirror of the write path using AR. The RD_WAIT exit condition is RVALID&RREADY&RLAST.
- Outside its ADDR state, each channel is blocked: m_xVALID = 0 and s_xREADY = 0.
- wr_active = state ∈ {WR_ADDR, WR_WAIT}; rd_active = state ∈ {RD_ADDR, RD_WAIT}.
- Watchdog:
  - The counter clears on entry to any WAIT state and increments each cycle while in that state.
  - If it reaches TIMEOUT−1 without completion: timeout_err = 1 for that cycle and the next state is IDLE.
  - Completion in that same cycle takes priority, so no error is raised.
  - No timeout in the ADDR states, because the master holds VALID there.
- Counters saturate at 2^CNT_WIDTH−1; they never wrap.
- R beats without RLAST, or a B handshake while not in WR_WAIT, do not change state.

## Timing
- Reset values: state = IDLE, last_grant = READ, all outputs 0, both counters 0, watchdog 0.
- ARESET asserted mid-burst: return to IDLE next edge and drop any grant without completion. No timeout_err is raised; counters clear.
- Arbitration latency: a request seen in IDLE at edge n enters ADDR at edge n+1. The earliest forwarded handshake is cycle n+1, because the gating is combinational from state.
- Completion at edge k → IDLE at k+1. A pending request is granted at k+2, giving 1 idle cycle between bursts.
- Back-to-back alternation: with both VALIDs held permanently, grant order is W, R, W, R…
- Same-cycle completion and new request: the completion is processed first; the new request is arbitrated in IDLE on the following cycle.

## Test plan
- Single write: s_AWVALID=1 at cycle 1, m_AWREADY=1, BVALID&BREADY at cycle 6.
  - Expect m_AWVALID high at cycle 2 and wr_active high cycles 2–6, back to IDLE at 7.
  - Expect wr_grant_cnt=1 and rd_grant_cnt=0.
- Contention: both VALIDs held for 4 bursts, each completing after 3 cycles.
  - Expect grant order W, R, W, R.
  - Expect s_ARREADY=0 throughout every write grant, and both counters = 2.
- Read burst with RLAST on the 4th beat (AR LEN=3).
  - Expect rd_active to stay high across beats 1–3 and fall the cycle after beat 4.
- Timeout: TIMEOUT=8, grant a write, never assert BVALID.
  - Expect timeout_err pulse on the 8th WAIT cycle, then IDLE, and a pending read granted after that.
- Reset mid-burst: ARESET=1 during RD_WAIT.
  - Expect IDLE, all outputs 0, counters 0 and no timeout_err.
- Saturation: CNT_WIDTH=2, 5 writes.
  - Expect wr_grant_cnt to stick at 3.
